blk_reader: RTL and testbench
=============================

BLK_READER -- requirements
Module: blk_reader

Interface
REQ-001 Parameter DW, 8: data word width in bits.
REQ-002 Parameter DEPTH, 8: FIFO depth in words, power of two; AW = log2(DEPTH).
REQ-003 Port clk_inputport  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port valid  in  1: word-available level from the upstream input port, already registered on clk_inputport.
REQ-006 Port data_in  in  DW: data word, stable while valid=1.
REQ-007 Port start  in  1: one-cycle request to begin a block read.
REQ-008 Port blk_len  in  8: number of words in the block, sampled on an accepted start.
REQ-009 Port rd_en  in  1: downstream pop request.
REQ-010 Port data_out  out  DW: FIFO head word (first-word fall-through); meaningful only when empty=0.
REQ-011 Port empty / full  out  1 each: FIFO status flags.
REQ-012 Port level  out  AW+1: FIFO occupancy, 0..DEPTH.
REQ-013 Port busy  out  1: high in READ and DRAIN states.
REQ-014 Port blk_done  out  1: one-cycle pulse at block completion.
REQ-015 Port overflow  out  1: sticky; a word was dropped because the FIFO was full.
REQ-016 Port words_rcvd  out  8: words accepted in the current or last block.

Function
REQ-017 Word capture: a word is accepted only in the cycle where valid=1 and the registered previous value of valid is 0 (rising-edge detect); a valid held high for multiple cycles yields exactly one word.
REQ-018 FSM states: IDLE, READ, DRAIN, DONE.
REQ-019 IDLE: start=1 with blk_len!=0 -> READ next cycle; blk_len latched; words_rcvd cleared; overflow cleared.
REQ-020 IDLE: start=1 with blk_len=0 is ignored; FSM stays in IDLE.
REQ-021 start is ignored in every state other than IDLE.
REQ-022 READ: each accepted word increments words_rcvd by 1 and is pushed into the FIFO if a push is permitted.
REQ-023 Push is permitted when full=0, or when full=1 and rd_en=1 in the same cycle (simultaneous pop and push; level unchanged).
REQ-024 A word accepted in READ while a push is not permitted is dropped, still counted in words_rcvd, and sets overflow.
REQ-025 READ -> DRAIN in the cycle after words_rcvd reaches the latched blk_len.
REQ-026 DRAIN: no capture; DRAIN -> DONE in the first cycle in which empty=1.
REQ-027 DONE: blk_done=1 for exactly that one cycle; DONE -> IDLE next cycle.
REQ-028 Words detected in IDLE, DRAIN or DONE are discarded; FIFO and words_rcvd are unchanged.
REQ-029 Pop: rd_en=1 with empty=0 advances the read pointer; rd_en=1 with empty=1 has no effect.
REQ-030 Pointers are AW bits and wrap modulo DEPTH; level is updated with +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-031 empty = (level==0); full = (level==DEPTH); both are derived from registered level with no extra latency.
REQ-032 Pop is serviced in every state, including IDLE after the block has completed.

Reset
REQ-033 reset=1 at a clock edge forces state=IDLE, level=0, both pointers=0, words_rcvd=0, overflow=0, blk_done=0, and edge-detect register=0 in any state, including mid-block.
REQ-034 After reset, empty=1, full=0, busy=0; FIFO memory contents are not reset and data_out is undefined while empty=1.
REQ-035 A valid=1 held across reset release counts as a new edge only after it returns to 0 and rises again, because the edge-detect register loads valid in the first cycle after reset.

Verification
REQ-036 Scenario: start with blk_len=4, four valid pulses with data 0x11, 0x22, 0x33, 0x44, rd_en=0 -> level=4, words_rcvd=4, DRAIN state; then rd_en=1 for 4 cycles -> data_out sequence 0x11..0x44, then blk_done pulses once, FSM returns to IDLE.
REQ-037 Scenario: start with blk_len=10, 10 pulses, no pops, DEPTH=8 -> level=8, overflow=1, words_rcvd=10, FIFO holds the first 8 words.
REQ-038 Scenario: FIFO full and rd_en=1 coincide with an accepted word -> level stays 8, overflow stays 0, new word appears at the tail.
REQ-039 Scenario: valid held high for 5 cycles in READ -> exactly 1 word accepted; start with blk_len=0 -> FSM stays in IDLE; valid pulses in IDLE -> level stays 0.
REQ-040 Scenario: reset asserted after 3 of 6 words -> the next cycle has IDLE, level=0, words_rcvd=0, empty=1, and no blk_done pulse.
REQ-041 Scenario: 20 words pushed and popped one per cycle in a single block of blk_len=20 -> pointers wrap, data order is preserved, and overflow=0.

Source files
------------

// File: rtl/blk_reader.sv
// Block reader: captures one word per rising edge of valid into a FWFT FIFO
// and tracks a block of blk_len words through READ, DRAIN and DONE.
module blk_reader #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_inputport,
    input  logic          reset,
    input  logic          valid,
    input  logic [DW-1:0] data_in,
    input  logic          start,
    input  logic [7:0]    blk_len,
    input  logic          rd_en,
    output logic [DW-1:0] data_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          blk_done,
    output logic          overflow,
    output logic [7:0]    words_rcvd
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    len_q;
    logic          valid_q;
    logic          word_edge, accept, push, pop, go;

    assign word_edge = valid & ~valid_q;
    assign accept    = word_edge && (state == READ);
    assign empty     = (level == '0);
    assign full      = (level == (AW+1)'(DEPTH));
    // A full FIFO can still take a word if the head leaves in the same cycle.
    assign push      = accept && (!full || rd_en);
    assign pop       = rd_en && !empty;
    assign go        = start && (blk_len != 8'd0) && (state == IDLE);
    assign data_out  = mem[rd_ptr];
    assign busy      = (state == READ) || (state == DRAIN);
    assign blk_done  = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (go) state_nx = READ;
            READ:  if (accept && (words_rcvd + 8'd1 == len_q)) state_nx = DRAIN;
            DRAIN: if (empty) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_inputport) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            len_q      <= 8'd0;
            words_rcvd <= 8'd0;
            overflow   <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_q <= valid;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + (AW+1)'(1);
            else if (pop && !push) level <= level - (AW+1)'(1);
            if (go) begin
                len_q      <= blk_len;
                words_rcvd <= 8'd0;
                overflow   <= 1'b0;
            end else if (accept) begin
                words_rcvd <= words_rcvd + 8'd1;
                if (!push) overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_inputport) begin
        if (push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_blk_reader.sv
// Directed self-checking bench for blk_reader.
module tb_blk_reader;

    logic       clk_inputport = 1'b0;
    logic       reset;
    logic       valid;
    logic [7:0] data_in;
    logic       start;
    logic [7:0] blk_len;
    logic       rd_en;
    logic [7:0] data_out;
    logic       empty, full, busy, blk_done, overflow;
    logic [3:0] level;
    logic [7:0] words_rcvd;

    int checks = 0;
    int errors = 0;

    blk_reader #(.DW(8), .DEPTH(8)) dut (
        .clk_inputport(clk_inputport),
        .reset(reset),
        .valid(valid),
        .data_in(data_in),
        .start(start),
        .blk_len(blk_len),
        .rd_en(rd_en),
        .data_out(data_out),
        .empty(empty),
        .full(full),
        .level(level),
        .busy(busy),
        .blk_done(blk_done),
        .overflow(overflow),
        .words_rcvd(words_rcvd)
    );

    always #5 clk_inputport = ~clk_inputport;

    task automatic tick();
        @(posedge clk_inputport);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        valid   = 1'b1;
        data_in = d;
        tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic begin_blk(input logic [7:0] n);
        start   = 1'b1;
        blk_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && busy; i++) tick();
        chk("idle_reached", busy, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; data_in = 8'h00;
        start = 1'b0; blk_len = 8'd0; rd_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_words", words_rcvd, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", blk_done, 0);

        // Basic block of four words, popped in DRAIN
        begin_blk(8'd4);
        chk("s1_busy", busy, 1);
        pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
        pulse(8'h55);
        chk("s1_level", level, 4);
        chk("s1_words", words_rcvd, 4);
        chk("s1_busy_drain", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk("s1_data", data_out, 32'h11 * (i + 1));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("s1_empty", empty, 1);
        chk("s1_no_done_yet", blk_done, 0);
        tick();
        chk("s1_done_pulse", blk_done, 1);
        tick();
        chk("s1_done_clear", blk_done, 0);
        chk("s1_idle", busy, 0);

        // Overflow: ten words into an eight-deep FIFO
        begin_blk(8'd10);
        for (int i = 0; i < 10; i++) pulse(8'hA0 + 8'(i));
        chk("s2_level", level, 8);
        chk("s2_full", full, 1);
        chk("s2_ovf", overflow, 1);
        chk("s2_words", words_rcvd, 10);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("s2_data", data_out, 32'hA0 + i);
            tick();
        end
        rd_en = 1'b0;
        wait_idle();

        // Simultaneous pop and push while full
        begin_blk(8'd9);
        chk("s3_ovf_cleared", overflow, 0);
        for (int i = 0; i < 8; i++) pulse(8'hB0 + 8'(i));
        chk("s3_full", full, 1);
        valid = 1'b1; data_in = 8'hB8; rd_en = 1'b1;
        tick();
        valid = 1'b0; rd_en = 1'b0;
        tick();
        chk("s3_level", level, 8);
        chk("s3_ovf", overflow, 0);
        chk("s3_words", words_rcvd, 9);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("s3_data", data_out, 32'hB1 + i);
            tick();
        end
        rd_en = 1'b0;
        chk("s3_empty", empty, 1);
        wait_idle();

        // Zero-length start, IDLE pulses, held valid
        begin_blk(8'd0);
        chk("s4_len0_idle", busy, 0);
        pulse(8'hEE); pulse(8'hEF);
        chk("s4_idle_level", level, 0);
        begin_blk(8'd2);
        valid = 1'b1; data_in = 8'hC1;
        for (int i = 0; i < 5; i++) tick();
        valid = 1'b0;
        tick();
        chk("s4_held_words", words_rcvd, 1);
        chk("s4_held_level", level, 1);
        pulse(8'hC2);
        chk("s4_words", words_rcvd, 2);
        rd_en = 1'b1;
        chk("s4_data0", data_out, 32'hC1);
        tick();
        chk("s4_data1", data_out, 32'hC2);
        tick();
        rd_en = 1'b0;
        wait_idle();

        // Reset mid-block, valid held across reset release
        begin_blk(8'd6);
        pulse(8'hD0); pulse(8'hD1); pulse(8'hD2);
        chk("s5_pre_level", level, 3);
        valid = 1'b1; data_in = 8'hD3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_level", level, 0);
        chk("s5_words", words_rcvd, 0);
        chk("s5_empty", empty, 1);
        chk("s5_done", blk_done, 0);
        begin_blk(8'd1);
        tick(); tick();
        chk("s5_held_words", words_rcvd, 0);
        valid = 1'b0;
        tick();
        pulse(8'hD4);
        chk("s5_new_edge", words_rcvd, 1);
        chk("s5_data", data_out, 32'hD4);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        wait_idle();

        // Twenty words streamed through, pointers wrap
        begin_blk(8'd20);
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1;
            data_in = 8'h40 + 8'(i * 3);
            tick();
            valid = 1'b0;
            chk("s6_data", data_out, 32'h40 + i * 3);
            tick();
        end
        chk("s6_words", words_rcvd, 20);
        chk("s6_ovf", overflow, 0);
        rd_en = 1'b0;
        wait_idle();
        chk("s6_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
